// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver feeding a show-ahead byte FIFO with sticky error flags.
// Ports:
//   clk_in     system clock
//   rst_n      asynchronous active-low reset
//   rx         serial input, idle high
//   rd_en      pop FIFO head (ignored when empty)
//   rd_data    FIFO head byte, valid while empty==0
//   empty      FIFO empty
//   full       FIFO full
//   count      bytes held
//   byte_valid one-cycle pulse per good frame (pushed or dropped)
//   frame_err  sticky: stop bit sampled low
//   overflow   sticky: good byte arrived while full
//   clear_err  synchronous clear of frame_err and overflow
module uart_rx_capture #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             byte_valid,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clear_err
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state, state_d;
    logic rx_m, rx_s;
    logic [BW-1:0] bit_cnt, cnt_d;
    logic [2:0] idx, idx_d;
    logic [7:0] shift, shift_d;
    logic good_d, good_r, fe_set, ov_set, push, pop;
    logic [7:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_d;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            shift   <= '0;
            good_r  <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            state   <= state_d;
            bit_cnt <= cnt_d;
            idx     <= idx_d;
            shift   <= shift_d;
            good_r  <= good_d;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = bit_cnt + BW'(1);
        idx_d   = idx;
        shift_d = shift;
        good_d  = 1'b0;
        fe_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (bit_cnt == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_cnt == LAST) begin
                cnt_d        = '0;
                shift_d[idx] = rx_s;
                idx_d        = idx + 3'd1;
                if (idx == 3'd7) state_d = STOP;
            end
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            STOP: if (bit_cnt == LAST) begin
                cnt_d   = '0;
                good_d  = rx_s;
                fe_set  = !rx_s;
                state_d = rx_s ? IDLE : BRK;
            end
            // A held-low line waits here so it raises only one framing error.
            BRK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // A simultaneous pop frees the slot, so a push while full is still accepted.
    assign push    = good_r & (~full | rd_en);
    assign pop     = rd_en & ~empty;
    assign ov_set  = good_r & full & ~rd_en;
    assign count_d = count + CNT_W'(push) - CNT_W'(pop);
    assign rd_data = mem[rd_ptr];
    assign byte_valid = good_r;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) mem[wr_ptr] <= shift;
            wr_ptr    <= wr_ptr + PW'(push);
            rd_ptr    <= rd_ptr + PW'(pop);
            count     <= count_d;
            empty     <= count_d == '0;
            full      <= count_d == CNT_W'(FIFO_DEPTH);
            frame_err <= fe_set | (frame_err & ~clear_err);
            overflow  <= ov_set | (overflow & ~clear_err);
        end
    end
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed self-checking bench for uart_rx_capture (8 clocks/bit, depth 4).
module tb_uart_rx_capture;
    localparam int CPB = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic rd_en = 1'b0;
    logic clear_err = 1'b0;
    logic [7:0] rd_data;
    logic empty, full, byte_valid, frame_err, overflow;
    logic [CW-1:0] count;
    int passed = 0;
    int total = 0;
    int bv_cnt = 0;
    uart_rx_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .byte_valid(byte_valid),
        .frame_err(frame_err), .overflow(overflow), .clear_err(clear_err)
    );
    always #5 clk_in = ~clk_in;
    always @(negedge clk_in) if (byte_valid) bv_cnt++;
    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
    endtask
    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk_in);
        rd_en = 1'b0;
    endtask
    initial begin
        int bv0;
        logic got;
        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h01, 8'h01};
        vecs[2] = '{8'h80, 8'h80};
        vecs[3] = '{8'hC3, 8'hC3};
        vecs[4] = '{8'h00, 8'h00};
        vecs[5] = '{8'hFE, 8'hFE};
        idle(3);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_bv", byte_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", rd_data, 0);
        rst_n = 1'b1;
        idle(10);
        for (int v = 0; v < 6; v++) begin
            bv0 = bv_cnt;
            send(vecs[v].tx, 1'b1);
            rx = 1'b1;
            idle(4);
            chk("vec_bv", bv_cnt - bv0, 1);
            chk("vec_count", count, 1);
            chk("vec_empty", empty, 0);
            pop_chk("vec_data", vecs[v].exp_data);
            idle(1);
            chk("vec_empty_after", empty, 1);
            chk("vec_count_after", count, 0);
        end
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        send(8'h3C, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("b2b_full", full, 1);
        chk("b2b_count", count, 4);
        chk("b2b_ovf", overflow, 0);
        send(8'h77, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", rd_data, 8'h00);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        idle(1);
        chk("ovf_clear", overflow, 0);
        pop_chk("drain0", 8'h00);
        pop_chk("drain1", 8'hFF);
        pop_chk("drain2", 8'h55);
        pop_chk("drain3", 8'h3C);
        idle(1);
        chk("drain_empty", empty, 1);
        send(8'h9A, 1'b1);
        send(8'hB6, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("wrap_count", count, 2);
        pop_chk("wrap0", 8'h9A);
        pop_chk("wrap1", 8'hB6);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("fill_full", full, 1);
        got = 1'b0;
        fork
            begin
                send(8'h77, 1'b1);
                rx = 1'b1;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk_in);
                    if (byte_valid) begin
                        rd_en = 1'b1;
                        @(negedge clk_in);
                        rd_en = 1'b0;
                        got = 1'b1;
                        break;
                    end
                end
            end
        join
        idle(4);
        chk("pr_seen", got, 1);
        chk("pr_ovf", overflow, 0);
        chk("pr_count", count, 4);
        pop_chk("pr0", 8'h22);
        pop_chk("pr1", 8'h33);
        pop_chk("pr2", 8'h44);
        pop_chk("pr3", 8'h77);
        idle(1);
        chk("pr_empty", empty, 1);
        bv0 = bv_cnt;
        send(8'h5A, 1'b0);
        idle(10);
        chk("fe_set", frame_err, 1);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        idle(30);
        chk("fe_once", frame_err, 0);
        chk("fe_nopush", count, 0);
        chk("fe_nobv", bv_cnt - bv0, 0);
        rx = 1'b1;
        idle(10);
        send(8'h12, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("fe_next_count", count, 1);
        chk("fe_next_ferr", frame_err, 0);
        pop_chk("fe_next_data", 8'h12);
        bv0 = bv_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(100);
        chk("gl_count", count, 0);
        chk("gl_bv", bv_cnt - bv0, 0);
        chk("gl_ferr", frame_err, 0);
        chk("gl_ovf", overflow, 0);
        send(8'hE1, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("gl_next_count", count, 1);
        rx = 1'b0;
        idle(CPB + 3 * CPB);
        rst_n = 1'b0;
        idle(1);
        chk("mr_empty", empty, 1);
        chk("mr_count", count, 0);
        chk("mr_data", rd_data, 0);
        chk("mr_bv", byte_valid, 0);
        rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        bv0 = bv_cnt;
        idle(100);
        chk("mr_nopartial", count, 0);
        chk("mr_nobv", bv_cnt - bv0, 0);
        send(8'h3C, 1'b1);
        rx = 1'b1;
        idle(4);
        chk("mr_next_count", count, 1);
        pop_chk("mr_next_data", 8'h3C);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
